ram_2p_ctrl: RTL and testbench

Parametrised two-port (one write, one read) synchronous RAM controller, next generation of the team's single-port RAM DUT. Adds byte-enabled writes, a configurable read pipeline depth, selectable read/write collision policy, out-of-range address detection and a hardware clear sequencer that fills the array after reset or on request. It sits as the leaf storage block under the RAM verification environment.

---
 rtl/ram_2p_pkg.sv | 24 ++
 rtl/ram_2p_clr_seq.sv | 61 ++++++
 rtl/ram_2p_ctrl.sv | 131 +++++++++++++
 tb/tb_ram_2p_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_2p_pkg.sv
// Shared types, constants and parameter checks for the two-port RAM controller.
// Also imported by the bench.
package ram_2p_pkg;

  typedef enum logic [0:0] {
    StInit,
    StReady
  } clr_state_e;

  localparam int unsigned COLL_READ_FIRST  = 0;
  localparam int unsigned COLL_WRITE_FIRST = 1;

  function automatic int unsigned byte_lanes(int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic bit params_ok(int unsigned data_w, int unsigned addr_w, int unsigned depth,
                                   int unsigned rd_lat, int unsigned coll_mode);
    params_ok = (data_w > 0) && (data_w % 8 == 0) && (depth > 0) && (addr_w > 0) &&
                (addr_w < 32) && (longint'(depth) <= (longint'(1) << addr_w)) &&
                (rd_lat == 1 || rd_lat == 2) && (coll_mode <= 1);
  endfunction

endpackage

// File: rtl/ram_2p_clr_seq.sv
// Clear sequencer: sweeps every address once after reset or on clr_req,
// holding busy high while the sweep runs.
module ram_2p_clr_seq
  import ram_2p_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StInit: begin
        if (cnt_q == LastAddr) begin
          state_d = StReady;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReady: begin
        if (clr_req) begin
          state_d = StInit;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy       = (state_q == StInit);
  assign sweep_we   = busy;
  assign sweep_addr = cnt_q;

endmodule

// File: rtl/ram_2p_ctrl.sv
// Two-port (1W/1R) RAM with byte enables, collision policy, range checking,
// a 1- or 2-stage read pipeline and a hardware clear sequencer.
module ram_2p_ctrl
  import ram_2p_pkg::*;
#(
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        ADDR_W    = 8,
  parameter int unsigned        DEPTH     = 200,
  parameter int unsigned        RD_LAT    = 1,
  parameter int unsigned        COLL_MODE = 0,
  parameter logic [DATA_W-1:0]  CLR_VAL   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_enb,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  rd_enb,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic                  clr_req,
  output logic [DATA_W-1:0]     data_out,
  output logic                  rd_valid,
  output logic                  rd_err,
  output logic                  wr_err,
  output logic                  busy
);

  localparam int unsigned NumBytes = byte_lanes(DATA_W);
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

  if (!params_ok(DATA_W, ADDR_W, DEPTH, RD_LAT, COLL_MODE)) begin : g_bad_params
    $error("ram_2p_ctrl: illegal parameter combination");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;

  ram_2p_clr_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clr_seq (
    .clk        (clk),
    .rst        (rst),
    .clr_req    (clr_req),
    .busy       (busy),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  logic              wr_ok, rd_ok, coll;
  logic [DATA_W-1:0] rd_word, coll_word, rd_data;

  assign wr_ok   = wr_enb && !busy && ({1'b0, wr_addr} < DepthLim);
  assign rd_ok   = rd_enb && !busy && ({1'b0, rd_addr} < DepthLim);
  assign coll    = wr_ok && rd_ok && (wr_addr == rd_addr);
  assign rd_word = mem[rd_addr];

  always_comb begin
    coll_word = rd_word;
    for (int i = 0; i < NumBytes; i++) begin
      if (wr_be[i]) coll_word[8*i +: 8] = data_in[8*i +: 8];
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_ok) begin
      rd_data = (coll && COLL_MODE == COLL_WRITE_FIRST) ? coll_word : rd_word;
    end
  end

  // The sweep only runs while busy, so it never competes with a user write.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= CLR_VAL;
    end else if (wr_ok) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= data_in[8*i +: 8];
      end
    end
  end

  logic              s1_valid_q, s1_err_q, wr_err_q;
  logic [DATA_W-1:0] s1_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_data_q  <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= rd_enb;
      s1_err_q   <= rd_enb && !rd_ok;
      if (rd_enb) s1_data_q <= rd_data;
      wr_err_q   <= wr_enb && !wr_ok;
    end
  end

  assign wr_err = wr_err_q;

  if (RD_LAT == 2) begin : g_lat2
    logic              s2_valid_q, s2_err_q;
    logic [DATA_W-1:0] s2_data_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_err_q   <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_err_q   <= s1_err_q;
        if (s1_valid_q) s2_data_q <= s1_data_q;
      end
    end

    assign rd_valid = s2_valid_q;
    assign rd_err   = s2_err_q;
    assign data_out = s2_data_q;
  end else begin : g_lat1
    assign rd_valid = s1_valid_q;
    assign rd_err   = s1_err_q;
    assign data_out = s1_data_q;
  end

endmodule

// File: tb/tb_ram_2p_ctrl.sv
// Directed bench: dut0 is read-first with latency 1, dut1 is write-first with
// latency 2; both share stimulus and are checked against hand-computed values.
module tb_ram_2p_ctrl;
  import ram_2p_pkg::*;

  localparam logic [31:0] ClrVal = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_enb = 1'b0, rd_enb = 1'b0, clr_req = 1'b0;
  logic [7:0]  wr_addr = '0, rd_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] data_in = '0;

  logic [31:0] data_out0, data_out1;
  logic        rd_valid0, rd_valid1, rd_err0, rd_err1, wr_err0, wr_err1, busy0, busy1;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  // Captured results of the last issue() call.
  logic        c_v0, c_e0, c_v1, c_e1, c_we0, c_we1, c_we0_s2, c_busy;
  logic [31:0] c_d0, c_d1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_2p_ctrl #(
    .DATA_W(32), .ADDR_W(8), .DEPTH(200), .RD_LAT(1), .COLL_MODE(COLL_READ_FIRST), .CLR_VAL(ClrVal)
  ) dut0 (
    .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_be(wr_be), .data_in(data_in),
    .rd_enb(rd_enb), .rd_addr(rd_addr), .clr_req(clr_req), .data_out(data_out0),
    .rd_valid(rd_valid0), .rd_err(rd_err0), .wr_err(wr_err0), .busy(busy0)
  );

  ram_2p_ctrl #(
    .DATA_W(32), .ADDR_W(8), .DEPTH(200), .RD_LAT(2), .COLL_MODE(COLL_WRITE_FIRST), .CLR_VAL(ClrVal)
  ) dut1 (
    .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_be(wr_be), .data_in(data_in),
    .rd_enb(rd_enb), .rd_addr(rd_addr), .clr_req(clr_req), .data_out(data_out1),
    .rd_valid(rd_valid1), .rd_err(rd_err1), .wr_err(wr_err1), .busy(busy1)
  );

  // Drive one request cycle (caller sits at a negedge), capture dut0 and
  // wr_err one edge later, dut1 two edges later. Returns at a negedge.
  task automatic issue(input logic wen, input logic [7:0] waddr, input logic [3:0] wbe,
                       input logic [31:0] wdata, input logic ren, input logic [7:0] raddr);
    wr_enb = wen; wr_addr = waddr; wr_be = wbe; data_in = wdata;
    rd_enb = ren; rd_addr = raddr;
    @(negedge clk);
    c_v0 = rd_valid0; c_e0 = rd_err0; c_d0 = data_out0;
    c_we0 = wr_err0; c_we1 = wr_err1; c_busy = busy0;
    wr_enb = 1'b0; rd_enb = 1'b0; wr_be = '0;
    @(negedge clk);
    c_v1 = rd_valid1; c_e1 = rd_err1; c_d1 = data_out1; c_we0_s2 = wr_err0;
  endtask

  // Waits for busy to fall; returns posedges elapsed since entry (1000 = timeout).
  task automatic wait_ready(output int unsigned edges);
    int unsigned start;
    int n;
    start = cyc;
    n = 0;
    while (busy0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    edges = busy0 ? 1000 : cyc - start;
  endtask

  task automatic test_reset();
    int unsigned edges;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy0, busy1, rd_valid0, rd_valid1, rd_err0, rd_err1, wr_err0, wr_err1} !== 8'b1100_0000)
    begin
      failures++;
      $display("FAIL reset_flags got=%b exp=11000000",
               {busy0, busy1, rd_valid0, rd_valid1, rd_err0, rd_err1, wr_err0, wr_err1});
    end
    checks++;
    if (data_out0 !== 32'h0 || data_out1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h exp=0", data_out0, data_out1);
    end
    rst = 1'b0;
    wait_ready(edges);
    checks++;
    if (edges != 200 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL init_len got=%0d busy1=%b exp=200 busy1=0", edges, busy1);
    end
    issue(1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'd0);
    checks++;
    if ({c_v0, c_e0, c_v1, c_e1} !== 4'b1010 || c_d0 !== ClrVal || c_d1 !== ClrVal) begin
      failures++;
      $display("FAIL init_rd0 got=%b %h %h exp=1010 %h", {c_v0, c_e0, c_v1, c_e1}, c_d0, c_d1,
               ClrVal);
    end
    issue(1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'd199);
    checks++;
    if ({c_v0, c_e0, c_v1, c_e1} !== 4'b1010 || c_d0 !== ClrVal || c_d1 !== ClrVal) begin
      failures++;
      $display("FAIL init_rd199 got=%b %h %h exp=1010 %h", {c_v0, c_e0, c_v1, c_e1}, c_d0, c_d1,
               ClrVal);
    end
  endtask

  task automatic test_byte_enable();
    issue(1'b1, 8'd5, 4'b0101, 32'h1122_3344, 1'b0, 8'd0);
    checks++;
    if (c_we0 !== 1'b0 || c_we1 !== 1'b0) begin
      failures++;
      $display("FAIL be_wr_err got=%b%b exp=00", c_we0, c_we1);
    end
    issue(1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'd5);
    checks++;
    if (c_d0 !== 32'hA522_A544 || c_d1 !== 32'hA522_A544) begin
      failures++;
      $display("FAIL be_merge got=%h/%h exp=a522a544", c_d0, c_d1);
    end
    // All-zero byte enables: legal no-op, no error.
    issue(1'b1, 8'd5, 4'b0000, 32'hFFFF_FFFF, 1'b1, 8'd5);
    issue(1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'd5);
    checks++;
    if (c_we0 !== 1'b0 || c_d0 !== 32'hA522_A544 || c_d1 !== 32'hA522_A544) begin
      failures++;
      $display("FAIL be_zero got=%b %h/%h exp=0 a522a544", c_we0, c_d0, c_d1);
    end
  endtask

  task automatic test_collision();
    issue(1'b1, 8'd7, 4'hF, 32'h0, 1'b0, 8'd0);
    issue(1'b1, 8'd7, 4'hF, 32'hDEAD_BEEF, 1'b1, 8'd7);
    checks++;
    if (c_d0 !== 32'h0 || c_d1 !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL coll_full got=%h/%h exp=00000000/deadbeef", c_d0, c_d1);
    end
    issue(1'b1, 8'd7, 4'b0011, 32'h1234_5678, 1'b1, 8'd7);
    checks++;
    if (c_d0 !== 32'hDEAD_BEEF || c_d1 !== 32'hDEAD_5678) begin
      failures++;
      $display("FAIL coll_part got=%h/%h exp=deadbeef/dead5678", c_d0, c_d1);
    end
    issue(1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'd7);
    checks++;
    if (c_d0 !== 32'hDEAD_5678 || c_d1 !== 32'hDEAD_5678) begin
      failures++;
      $display("FAIL coll_after got=%h/%h exp=dead5678", c_d0, c_d1);
    end
  endtask

  task automatic test_back_to_back();
    int n0, n1;
    for (int i = 0; i < 10; i++) issue(1'b1, 8'(i), 4'hF, 32'h1000_0000 + i, 1'b0, 8'd0);
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < 12; c++) begin
      // Sample before driving: dut0 shows read c-1, dut1 shows read c-2.
      if (c >= 1 && c <= 10) begin
        checks++;
        if (rd_valid0 !== 1'b1 || rd_err0 !== 1'b0 || data_out0 !== 32'h1000_0000 + (c - 1)) begin
          failures++;
          $display("FAIL b2b_lat1 slot=%0d got=%b%b %h exp=10 %h", c, rd_valid0, rd_err0,
                   data_out0, 32'h1000_0000 + (c - 1));
        end
      end
      if (c >= 2) begin
        checks++;
        if (rd_valid1 !== 1'b1 || rd_err1 !== 1'b0 || data_out1 !== 32'h1000_0000 + (c - 2)) begin
          failures++;
          $display("FAIL b2b_lat2 slot=%0d got=%b%b %h exp=10 %h", c, rd_valid1, rd_err1,
                   data_out1, 32'h1000_0000 + (c - 2));
        end
      end
      n0 += int'(rd_valid0);
      n1 += int'(rd_valid1);
      rd_enb  = (c < 10);
      rd_addr = 8'(c);
      @(negedge clk);
    end
    checks++;
    if (n0 != 10 || n1 != 10 || rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_count got=%0d/%0d exp=10/10", n0, n1);
    end
  endtask

  task automatic test_out_of_range();
    issue(1'b1, 8'd200, 4'hF, 32'hFFFF_FFFF, 1'b1, 8'd250);
    checks++;
    if ({c_we0, c_we1, c_we0_s2} !== 3'b110) begin
      failures++;
      $display("FAIL oor_wr_err got=%b exp=110", {c_we0, c_we1, c_we0_s2});
    end
    checks++;
    if ({c_v0, c_e0, c_v1, c_e1} !== 4'b1111 || c_d0 !== 32'h0 || c_d1 !== 32'h0) begin
      failures++;
      $display("FAIL oor_rd got=%b %h/%h exp=1111 0", {c_v0, c_e0, c_v1, c_e1}, c_d0, c_d1);
    end
    issue(1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'd199);
    checks++;
    if (c_d0 !== ClrVal || c_d1 !== ClrVal || c_e0 !== 1'b0) begin
      failures++;
      $display("FAIL oor_unchanged got=%h/%h exp=%h", c_d0, c_d1, ClrVal);
    end
    issue(1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'd72);
    checks++;
    if (c_d0 !== ClrVal || c_d1 !== ClrVal) begin
      failures++;
      $display("FAIL oor_alias got=%h/%h exp=%h", c_d0, c_d1, ClrVal);
    end
  endtask

  task automatic test_clear();
    int unsigned e, edges;
    issue(1'b1, 8'd3, 4'hF, 32'hCAFE_0003, 1'b0, 8'd0);
    clr_req = 1'b1; rd_enb = 1'b1; rd_addr = 8'd3;
    @(negedge clk);
    clr_req = 1'b0; rd_enb = 1'b0;
    e = cyc;
    checks++;
    if (busy0 !== 1'b1 || rd_valid0 !== 1'b1 || rd_err0 !== 1'b0 || data_out0 !== 32'hCAFE_0003)
    begin
      failures++;
      $display("FAIL clr_same_edge got=%b%b%b %h exp=110 cafe0003", busy0, rd_valid0, rd_err0,
               data_out0);
    end
    @(negedge clk);
    checks++;
    if (rd_valid1 !== 1'b1 || rd_err1 !== 1'b0 || data_out1 !== 32'hCAFE_0003) begin
      failures++;
      $display("FAIL clr_same_edge_lat2 got=%b%b %h exp=10 cafe0003", rd_valid1, rd_err1,
               data_out1);
    end
    issue(1'b1, 8'd3, 4'hF, 32'h0, 1'b1, 8'd3);
    checks++;
    if ({c_we0, c_v0, c_e0, c_v1, c_e1} !== 5'b11111 || c_d0 !== 32'h0 || c_d1 !== 32'h0) begin
      failures++;
      $display("FAIL clr_busy_reject got=%b %h/%h exp=11111 0", {c_we0, c_v0, c_e0, c_v1, c_e1},
               c_d0, c_d1);
    end
    wait_ready(edges);
    checks++;
    if (busy0 !== 1'b0 || cyc - e != 200) begin
      failures++;
      $display("FAIL clr_len got=%0d exp=200", (busy0 ? 1000 : cyc - e));
    end
    issue(1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'd3);
    checks++;
    if (c_d0 !== ClrVal || c_d1 !== ClrVal || c_e0 !== 1'b0) begin
      failures++;
      $display("FAIL clr_value got=%h/%h exp=%h", c_d0, c_d1, ClrVal);
    end
  endtask

  task automatic test_reset_mid_init();
    int unsigned edges;
    issue(1'b1, 8'd9, 4'hF, 32'h0BAD_F00D, 1'b0, 8'd0);
    rd_enb = 1'b1; rd_addr = 8'd9;
    @(negedge clk);
    rd_enb = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({rd_valid0, busy0, busy1} !== 3'b011 || data_out0 !== 32'h0) begin
      failures++;
      $display("FAIL rst_async got=%b %h exp=011 0", {rd_valid0, busy0, busy1}, data_out0);
    end
    @(negedge clk);
    checks++;
    if (rd_valid1 !== 1'b0 || data_out1 !== 32'h0) begin
      failures++;
      $display("FAIL rst_inflight got=%b %h exp=0 0", rd_valid1, data_out1);
    end
    rst = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready(edges);
    checks++;
    if (edges != 200) begin
      failures++;
      $display("FAIL rst_mid_init_len got=%0d exp=200", edges);
    end
    issue(1'b0, 8'd0, 4'h0, 32'h0, 1'b1, 8'd9);
    checks++;
    if (c_d0 !== ClrVal || c_d1 !== ClrVal || {c_v0, c_e0, c_v1, c_e1} !== 4'b1010) begin
      failures++;
      $display("FAIL rst_mid_init_rd got=%h/%h exp=%h", c_d0, c_d1, ClrVal);
    end
  endtask

  initial begin
    test_reset();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_out_of_range();
    test_clear();
    test_reset_mid_init();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
